md5_block_sequencer: RTL and testbench
======================================

Name: md5_block_sequencer

Overview:
- Top-level controller for the MD5 round datapath.
- Accepts 512-bit message blocks over a valid/ready handshake and owns the chaining registers H0..H3.
- Drives the round engine through rounds 0..3 with a start/done handshake, then performs the final chaining add.
- On the last block of a message, presents the 128-bit digest over a valid/ready handshake.

Parameters:
- N, 32, word width; fixed at 32, other values unsupported.
- TIMEOUT, 64, max cycles allowed in WAIT for eng_done_i before error abort; range 2..1023.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- blk_valid_i  in  1  message block offered.
- blk_ready_o  out  1  sequencer can accept a block.
- blk_last_i  in  1  offered block is the final block of the message.
- msg_i  in  512  block; msg_i[32k+31:32k] = M[k], k=0..15.
- eng_start_o  out  1  one-cycle pulse: engine loads state and runs one round.
- eng_round_o  out  2  round index for engine (0..3).
- eng_msg_o  out  512  latched block, stable from accept until ADD.
- eng_a_o, eng_b_o, eng_c_o, eng_d_o  out  32 each  round input state.
- eng_done_i  in  1  engine finished 16 steps; result valid this cycle.
- eng_a_i, eng_b_i, eng_c_i, eng_d_i  in  32 each  round result state.
- dig_valid_o  out  1  digest valid.
- dig_ready_i  in  1  digest consumer ready.
- dig_o  out  128  digest, byte 0 in dig_o[127:120].
- busy_o  out  1  state != IDLE.
- err_o  out  1  sticky engine-timeout flag.

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE, H0..H3 = 67452301, efcdab89, 98badcfe, 10325476.
  - Working regs, msg_q, round_q, last_q, timeout counter = 0.
  - err_o=0, eng_start_o=0, dig_valid_o=0, busy_o=0.
  - blk_ready_o=1 (combinational from state IDLE).
- States: IDLE, ISSUE, WAIT, ADD, OUT.
- IDLE:
  - blk_ready_o=1.
  - On blk_valid_i&blk_ready_o at edge: msg_q<=msg_i, last_q<=blk_last_i, working{a,b,c,d}<=H, round_q<=0, err_o<=0 → ISSUE.
- ISSUE:
  - eng_start_o=1 for exactly this cycle; eng_round_o=round_q; eng_*_o=working regs; timeout counter<=0 → WAIT.
- WAIT:
  - eng_*_o held.
  - On eng_done_i: working<=eng_*_i. If round_q==3 → ADD; else round_q<=round_q+1 → ISSUE.
  - Without done: counter+1. When counter reaches TIMEOUT-1 with no done: err_o<=1, H<=IV → IDLE; block discarded.
- eng_done_i is ignored in every state except WAIT; the same-cycle done on the timeout cycle wins (treated as done).
- ADD (1 cycle):
  - Hk<=Hk+working_k mod 2^32, carries dropped.
  - If last_q → OUT; else → IDLE with H retained for chaining.
- OUT:
  - dig_valid_o=1.
  - dig_o = {bswap(H0),bswap(H1),bswap(H2),bswap(H3)}, stable until accepted.
  - On dig_ready_i: H<=IV → IDLE.
  - dig_valid_o must not drop without the handshake.
- Latency with engine done L cycles after start (L≥1):
  - Accept edge to dig_valid_o = 4·(L+1)+2 cycles.
  - dig_valid_o same cycle as ADD+1.
- Blocks offered outside IDLE are not accepted (blk_ready_o=0); msg_i changes have no effect.
- eng_msg_o=msg_q at all times.
- Reset mid-operation returns to IDLE with IV in the same cycle; no partial digest is emitted.

Test Plan:
- Reset, no stimulus → blk_ready_o=1, busy_o=0, dig_valid_o=0, err_o=0, eng_start_o never pulses.
- Empty-string padded block (M[0]=00000080, rest 0, last=1), bench engine model L=16:
  - dig_o=d41d8cd98f00b204e9800998ecf8427e.
  - Exactly 4 eng_start_o pulses with eng_round_o 0,1,2,3.
  - Accept-to-valid = 70 cycles.
- "abc" padded block (M[0]=80636261, M[14]=00000018), last=1 → dig_o=900150983cd24fb0d6963f7d28e17f72.
- Two-block message (first last=0, second last=1):
  - After block 1, sequencer returns to IDLE with H≠IV and no dig_valid_o.
  - Final dig_o matches software MD5 of the 2-block message.
- Engine never asserts done:
  - err_o=1 exactly TIMEOUT cycles after the first start.
  - State returns to IDLE with blk_ready_o=1.
  - Next "abc" block gives the correct digest and clears err_o.
- dig_ready_i low 10 cycles: dig_o and dig_valid_o stable. Then dig_ready_i high 1 cycle → IDLE next cycle, H=IV.
- rst_i pulsed low during round 2 → immediate IDLE, no digest; next "abc" block gives the correct digest.

Source files
------------

// File: rtl/md5_block_sequencer.sv
// MD5 block sequencer: owns H0..H3, runs four rounds on an
// external round engine, and emits the digest on the last block.
module md5_block_sequencer #(
  parameter int N       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           blk_valid_i,
  output logic           blk_ready_o,
  input  logic           blk_last_i,
  input  logic [511:0]   msg_i,
  output logic           eng_start_o,
  output logic [1:0]     eng_round_o,
  output logic [511:0]   eng_msg_o,
  output logic [N-1:0]   eng_a_o,
  output logic [N-1:0]   eng_b_o,
  output logic [N-1:0]   eng_c_o,
  output logic [N-1:0]   eng_d_o,
  input  logic           eng_done_i,
  input  logic [N-1:0]   eng_a_i,
  input  logic [N-1:0]   eng_b_i,
  input  logic [N-1:0]   eng_c_i,
  input  logic [N-1:0]   eng_d_i,
  output logic           dig_valid_o,
  input  logic           dig_ready_i,
  output logic [4*N-1:0] dig_o,
  output logic           busy_o,
  output logic           err_o
);

  localparam logic [N-1:0] IV0 = 32'h67452301;
  localparam logic [N-1:0] IV1 = 32'hefcdab89;
  localparam logic [N-1:0] IV2 = 32'h98badcfe;
  localparam logic [N-1:0] IV3 = 32'h10325476;
  // Last WAIT cycle: counter+1 would reach TIMEOUT-1.
  localparam logic [9:0] CNT_LIM = 10'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ADD,
    S_OUT
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   h0_q, h1_q, h2_q, h3_q;
  logic [N-1:0]   h0_d, h1_d, h2_d, h3_d;
  logic [N-1:0]   a_q, b_q, c_q, d_q;
  logic [N-1:0]   a_d, b_d, c_d, d_d;
  logic [511:0]   msg_q, msg_d;
  logic [1:0]     round_q, round_d;
  logic           last_q, last_d;
  logic [9:0]     cnt_q, cnt_d;
  logic           err_q, err_d;

  function automatic logic [N-1:0] bswap(input logic [N-1:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Next-state and datapath updates for the block FSM
  always_comb begin
    state_d = state_q;
    h0_d    = h0_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    h3_d    = h3_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    msg_d   = msg_q;
    round_d = round_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (blk_valid_i) begin
          msg_d   = msg_i;
          last_d  = blk_last_i;
          a_d     = h0_q;
          b_d     = h1_q;
          c_d     = h2_q;
          d_d     = h3_q;
          round_d = 2'd0;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done_i) begin
          a_d = eng_a_i;
          b_d = eng_b_i;
          c_d = eng_c_i;
          d_d = eng_d_i;
          if (round_q == 2'd3) begin
            state_d = S_ADD;
          end else begin
            round_d = round_q + 2'd1;
            state_d = S_ISSUE;
          end
        end else if (cnt_q == CNT_LIM) begin
          err_d   = 1'b1;
          h0_d    = IV0;
          h1_d    = IV1;
          h2_d    = IV2;
          h3_d    = IV3;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_ADD: begin
        h0_d    = h0_q + a_q;
        h1_d    = h1_q + b_q;
        h2_d    = h2_q + c_q;
        h3_d    = h3_q + d_q;
        state_d = last_q ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        if (dig_ready_i) begin
          h0_d    = IV0;
          h1_d    = IV1;
          h2_d    = IV2;
          h3_d    = IV3;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      h0_q    <= IV0;
      h1_q    <= IV1;
      h2_q    <= IV2;
      h3_q    <= IV3;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      msg_q   <= '0;
      round_q <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      h3_q    <= h3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      msg_q   <= msg_d;
      round_q <= round_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign blk_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign eng_start_o = (state_q == S_ISSUE);
  assign dig_valid_o = (state_q == S_OUT);
  assign eng_round_o = round_q;
  assign eng_msg_o   = msg_q;
  assign eng_a_o     = a_q;
  assign eng_b_o     = b_q;
  assign eng_c_o     = c_q;
  assign eng_d_o     = d_q;
  assign err_o       = err_q;
  assign dig_o       = {bswap(h0_q), bswap(h1_q),
                        bswap(h2_q), bswap(h3_q)};

endmodule

// File: tb/tb_md5_block_sequencer.sv
// Bench for md5_block_sequencer with a behavioural MD5 round
// engine answering each start after a programmable latency.
module tb_md5_block_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid, blk_ready, blk_last;
  logic [511:0] msg;
  logic         eng_start;
  logic [1:0]   eng_round;
  logic [511:0] eng_msg;
  logic [31:0]  ea_o, eb_o, ec_o, ed_o;
  logic         eng_done;
  logic [31:0]  ea_i, eb_i, ec_i, ed_i;
  logic         dig_valid, dig_ready;
  logic [127:0] dig;
  logic         busy, err;

  int checks = 0;
  int failures = 0;

  localparam int TMO = 64;
  localparam logic [127:0] D_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] D_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] D_DIG   = 128'h57edf4a22be3c955ac49da2e2107b67a;

  md5_block_sequencer #(.N(32), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .blk_valid_i(blk_valid), .blk_ready_o(blk_ready),
    .blk_last_i(blk_last), .msg_i(msg),
    .eng_start_o(eng_start), .eng_round_o(eng_round),
    .eng_msg_o(eng_msg),
    .eng_a_o(ea_o), .eng_b_o(eb_o), .eng_c_o(ec_o), .eng_d_o(ed_o),
    .eng_done_i(eng_done),
    .eng_a_i(ea_i), .eng_b_i(eb_i), .eng_c_i(ec_i), .eng_d_i(ed_i),
    .dig_valid_o(dig_valid), .dig_ready_i(dig_ready), .dig_o(dig),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  logic [31:0] KT [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  function automatic int shamt(input int r, input int i);
    case (r)
      0: return (i % 4 == 0) ? 7 : (i % 4 == 1) ? 12 : (i % 4 == 2) ? 17 : 22;
      1: return (i % 4 == 0) ? 5 : (i % 4 == 1) ? 9  : (i % 4 == 2) ? 14 : 20;
      2: return (i % 4 == 0) ? 4 : (i % 4 == 1) ? 11 : (i % 4 == 2) ? 16 : 23;
      default: return (i % 4 == 0) ? 6 : (i % 4 == 1) ? 10 : (i % 4 == 2) ? 15 : 21;
    endcase
  endfunction

  function automatic logic [127:0] md5_round(
    input int r, input logic [31:0] a0, b0, c0, d0,
    input logic [511:0] m);
    logic [31:0] a, b, c, d, f, t, rot;
    int g, s;
    a = a0; b = b0; c = c0; d = d0;
    for (int i = 0; i < 16; i++) begin
      case (r)
        0: begin f = (b & c) | (~b & d); g = i; end
        1: begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2: begin f = b ^ c ^ d; g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d); g = (7 * i) % 16; end
      endcase
      t = f + a + KT[16 * r + i] + m[32 * g +: 32];
      s = shamt(r, i);
      rot = (t << s) | (t >> (32 - s));
      a = d; d = c; c = b; b = b + rot;
    end
    return {a, b, c, d};
  endfunction

  int           eng_l = 16;
  bit           eng_hang = 1'b0;
  int           ecnt = 0;
  logic [127:0] eres;
  int           nstart = 0;
  logic [1:0]   rlog [$];
  logic [31:0]  a0_last = '0;

  always @(negedge clk) begin
    eng_done = 1'b0;
    if (!rst_n) begin
      ecnt = 0;
    end else if (eng_start) begin
      nstart++;
      rlog.push_back(eng_round);
      if (eng_round == 2'd0) a0_last = ea_o;
      eres = md5_round(int'(eng_round), ea_o, eb_o, ec_o, ed_o, eng_msg);
      ecnt = eng_hang ? 0 : eng_l;
    end else if (ecnt > 0) begin
      ecnt--;
      if (ecnt == 0) begin
        eng_done = 1'b1;
        {ea_i, eb_i, ec_i, ed_i} = eres;
      end
    end
  end

  function automatic logic [511:0] blk_empty();
    logic [511:0] m = '0;
    m[31:0] = 32'h00000080;
    return m;
  endfunction

  function automatic logic [511:0] blk_abc();
    logic [511:0] m = '0;
    m[31:0]    = 32'h80636261;
    m[479:448] = 32'h00000018;
    return m;
  endfunction

  function automatic logic [511:0] blk_digits(input int b);
    logic [511:0] m = '0;
    int gi;
    for (int j = 0; j < 64; j++) begin
      gi = 64 * b + j;
      if (gi < 80)
        m[8 * j +: 8] = (gi % 10 == 9) ? 8'h30 : 8'(49 + gi % 10);
      else if (gi == 80)
        m[8 * j +: 8] = 8'h80;
    end
    if (b == 1) m[479:448] = 32'h00000280;
    return m;
  endfunction

  task automatic send_block(input logic [511:0] m, input logic l,
                            output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (blk_ready) begin
        blk_valid = 1'b1;
        msg = m;
        blk_last = l;
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_valid(output bit ok, output int edges);
    ok = 1'b0;
    edges = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      edges++;
      #1;
      if (dig_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    dig_ready = 1'b1;
    @(posedge clk);
    #1;
    dig_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    blk_valid = 1'b0;
    blk_last = 1'b0;
    msg = '0;
    dig_ready = 1'b0;
    eng_done = 1'b0;
    {ea_i, eb_i, ec_i, ed_i} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({blk_ready, busy, dig_valid, err} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_outputs got rdy/busy/val/err=%b exp 1000",
               {blk_ready, busy, dig_valid, err});
    end
    checks++;
    if (nstart != 0) begin
      failures++;
      $display("FAIL reset_no_start got %0d starts exp 0", nstart);
    end
  endtask

  task automatic test_empty();
    bit ok;
    int e;
    nstart = 0;
    rlog.delete();
    send_block(blk_empty(), 1'b1, ok);
    wait_valid(ok, e);
    checks++;
    if (!ok || dig !== D_EMPTY) begin
      failures++;
      $display("FAIL empty_digest got %h exp %h", dig, D_EMPTY);
    end
    checks++;
    if (e + 1 != 4 * (eng_l + 1) + 2) begin
      failures++;
      $display("FAIL empty_latency got %0d exp %0d", e + 1,
               4 * (eng_l + 1) + 2);
    end
    checks++;
    if (nstart != 4) begin
      failures++;
      $display("FAIL empty_start_count got %0d exp 4", nstart);
    end
    checks++;
    if (rlog.size() != 4 || rlog[0] != 2'd0 || rlog[1] != 2'd1 ||
        rlog[2] != 2'd2 || rlog[3] != 2'd3) begin
      failures++;
      $display("FAIL empty_round_seq got size %0d exp 0,1,2,3", rlog.size());
    end
    consume();
  endtask

  task automatic test_abc();
    bit ok;
    int e;
    eng_l = 3;
    send_block(blk_abc(), 1'b1, ok);
    checks++;
    if (eng_msg !== blk_abc()) begin
      failures++;
      $display("FAIL abc_eng_msg got %h exp %h", eng_msg[63:0], 64'h80636261);
    end
    wait_valid(ok, e);
    checks++;
    if (!ok || dig !== D_ABC) begin
      failures++;
      $display("FAIL abc_digest got %h exp %h", dig, D_ABC);
    end
    consume();
    eng_l = 16;
  endtask

  task automatic test_two_block();
    bit ok, saw;
    int e;
    eng_l = 1;
    saw = 1'b0;
    send_block(blk_digits(0), 1'b0, ok);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (dig_valid) saw = 1'b1;
      if (!busy) break;
    end
    checks++;
    if (saw || busy || !blk_ready) begin
      failures++;
      $display("FAIL two_blk_mid got saw=%b busy=%b exp 0 0", saw, busy);
    end
    send_block(blk_digits(1), 1'b1, ok);
    wait_valid(ok, e);
    checks++;
    if (a0_last === 32'h67452301) begin
      failures++;
      $display("FAIL two_blk_chain got H0=%h exp not IV", a0_last);
    end
    checks++;
    if (!ok || dig !== D_DIG) begin
      failures++;
      $display("FAIL two_blk_digest got %h exp %h", dig, D_DIG);
    end
    consume();
    eng_l = 16;
  endtask

  task automatic test_timeout();
    bit ok;
    int k, e;
    eng_hang = 1'b1;
    send_block(blk_abc(), 1'b1, ok);
    checks++;
    if (eng_start !== 1'b1) begin
      failures++;
      $display("FAIL tmo_start got %b exp 1", eng_start);
    end
    k = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      k++;
      #1;
      if (err) break;
    end
    checks++;
    if (!err || k != TMO) begin
      failures++;
      $display("FAIL tmo_err_cycle got %0d err=%b exp %0d", k, err, TMO);
    end
    checks++;
    if (!blk_ready || busy) begin
      failures++;
      $display("FAIL tmo_idle got rdy=%b busy=%b exp 1 0", blk_ready, busy);
    end
    eng_hang = 1'b0;
    send_block(blk_abc(), 1'b1, ok);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_err_clear got %b exp 0", err);
    end
    wait_valid(ok, e);
    checks++;
    if (!ok || dig !== D_ABC) begin
      failures++;
      $display("FAIL tmo_recover got %h exp %h", dig, D_ABC);
    end
    consume();
  endtask

  task automatic test_backpressure();
    bit ok;
    int e, bad;
    eng_l = 2;
    send_block(blk_abc(), 1'b1, ok);
    wait_valid(ok, e);
    bad = 0;
    @(negedge clk);
    blk_valid = 1'b1;
    msg = blk_empty();
    blk_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!dig_valid || dig !== D_ABC || blk_ready) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_stable got %0d bad cycles exp 0", bad);
    end
    @(negedge clk);
    dig_ready = 1'b1;
    @(posedge clk);
    #1;
    dig_ready = 1'b0;
    blk_valid = 1'b0;
    checks++;
    if (busy || !blk_ready || dig_valid) begin
      failures++;
      $display("FAIL bp_release got busy=%b rdy=%b val=%b exp 0 1 0",
               busy, blk_ready, dig_valid);
    end
    send_block(blk_abc(), 1'b1, ok);
    wait_valid(ok, e);
    checks++;
    if (!ok || dig !== D_ABC) begin
      failures++;
      $display("FAIL bp_iv_restored got %h exp %h", dig, D_ABC);
    end
    consume();
    eng_l = 16;
  endtask

  task automatic test_reset_mid();
    bit ok, saw, hit;
    int e;
    send_block(blk_abc(), 1'b1, ok);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (eng_start && eng_round == 2'd2) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL rstmid_round2 got no round-2 start exp one");
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy || !blk_ready || dig_valid || eng_start) begin
      failures++;
      $display("FAIL rstmid_idle got busy=%b rdy=%b val=%b exp 0 1 0",
               busy, blk_ready, dig_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      #1;
      if (dig_valid || busy) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      failures++;
      $display("FAIL rstmid_no_digest got activity exp none");
    end
    send_block(blk_abc(), 1'b1, ok);
    wait_valid(ok, e);
    checks++;
    if (!ok || dig !== D_ABC) begin
      failures++;
      $display("FAIL rstmid_recover got %h exp %h", dig, D_ABC);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_two_block();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
